virq_arbiter: RTL and testbench

Shares the CPU's single vectored-interrupt input between up to N peripheral requesters. The keyboard's 060/274 requests, the timer and the serial port each present a level request. The block grants one requester at a time, drives its vector to the CPU, and returns an acknowledge pulse to the granted requester so that it clears its own request. It sits between the peripheral `virq_req*`/`virq_ack*` pairs and the CPU's `virq`/`iako` pins.

---
 rtl/virq_arbiter.sv | 170 +++++++++++++++++
 tb/tb_virq_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/virq_arbiter.sv
// Vectored-interrupt arbiter: grants one of N level requesters to the CPU's single
// vectored-interrupt input, drives its vector and returns an acknowledge pulse.
module virq_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned RR      = 0,
  parameter int unsigned ACK_LEN = 2,
  parameter int unsigned DROP_TO = 64
) (
  input  logic             clk_sys,
  input  logic             bus_reset_n,
  input  logic             irq_en,
  input  logic [N-1:0]     req,
  input  logic [N*9-1:0]   vec_in,
  output logic [N-1:0]     ack,
  output logic             cpu_virq,
  output logic [15:0]      cpu_vector,
  input  logic             cpu_iako,
  output logic             busy
);

  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned VEC_W  = 9;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned ACK_W  = 4;
  localparam int unsigned DROP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_ACK   = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                iako_q;
  logic                rst_meta, rst_n;

  logic [N-1:0]        elig_c;
  logic                win_vld_c;
  logic [IDX_W-1:0]    win_idx_c;
  logic [VEC_W-1:0]    win_vec_c;
  logic                iako_rise_c;
  logic                req_g_c;
  logic [N-1:0]        gidx_onehot_c;

  // Reset asserts asynchronously, releases two clk_sys edges later.
  always_ff @(posedge clk_sys or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign elig_c        = req & {N{irq_en}};
  assign iako_rise_c   = cpu_iako & ~iako_q;
  assign req_g_c       = req[gidx_q];
  assign gidx_onehot_c = N'(1) << gidx_q;

  // Winner search: lowest index, or rotating from the slot after the last grant.
  always_comb begin : p_win
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    win_vec_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand     = (RR != 0) ? ((32'(last_q) + 32'd1 + k) % N) : k;
      cand_idx = IDX_W'(cand);
      if (!win_vld_c && elig_c[cand_idx]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand_idx;
        win_vec_c = vec_in[VEC_W*cand +: VEC_W];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gidx_q     <= '0;
      last_q     <= IDX_W'(N - 1);
      vec_q      <= '0;
      ack_cnt_q  <= '0;
      drop_cnt_q <= '0;
      iako_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      vec_q      <= vec_d;
      ack_cnt_q  <= ack_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      iako_q     <= cpu_iako;
    end
  end

  // Grant sequencing; an iako edge in OFFER takes precedence over a withdraw.
  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    vec_d      = vec_q;
    ack_cnt_d  = ack_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld_c) begin
          state_d = ST_OFFER;
          gidx_d  = win_idx_c;
          vec_d   = win_vec_c & ~VEC_W'(1);
        end
      end
      ST_OFFER: begin
        if (iako_rise_c) begin
          state_d   = ST_ACK;
          ack_cnt_d = ACK_W'(ACK_LEN);
          if (RR != 0) begin
            last_d = gidx_q;
          end
        end else if (!req_g_c || !irq_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (ack_cnt_q <= ACK_W'(1)) begin
          state_d    = ST_DROP;
          ack_cnt_d  = '0;
          drop_cnt_d = DROP_W'(DROP_TO);
        end else begin
          ack_cnt_d = ack_cnt_q - ACK_W'(1);
        end
      end
      ST_DROP: begin
        if (!req_g_c || drop_cnt_q <= DROP_W'(1)) begin
          state_d    = ST_IDLE;
          drop_cnt_d = '0;
        end else begin
          drop_cnt_d = drop_cnt_q - DROP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs follow the state one edge later.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= '0;
      cpu_virq   <= 1'b0;
      cpu_vector <= '0;
      busy       <= 1'b0;
    end else begin
      ack        <= (state_q == ST_ACK) ? gidx_onehot_c : '0;
      cpu_virq   <= (state_q == ST_OFFER);
      cpu_vector <= (state_q == ST_OFFER) ? OUT_W'(vec_q) : '0;
      busy       <= (state_q != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_virq_arbiter.sv
// Bench for virq_arbiter: a fixed-priority and a round-robin instance, each shadowed
// by a grant-level model, plus directed scenarios with literal expectations.
module tb_virq_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned ACK_LEN = 2;
  localparam int unsigned DROP_TO = 64;

  logic             clk_sys = 1'b0;
  logic             bus_reset_n;
  logic [N*9-1:0]   vec_in;
  logic [N-1:0]     req_a    [2];
  logic             irq_en_a [2];
  logic             iako_a   [2];
  logic [N-1:0]     ack_o    [2];
  logic             virq_o   [2];
  logic [15:0]      vec_o    [2];
  logic             busy_o   [2];

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk_sys = ~clk_sys;

  virq_arbiter #(.N(N), .RR(0), .ACK_LEN(ACK_LEN), .DROP_TO(DROP_TO)) u_fix (
    .clk_sys(clk_sys), .bus_reset_n(bus_reset_n), .irq_en(irq_en_a[0]), .req(req_a[0]),
    .vec_in(vec_in), .ack(ack_o[0]), .cpu_virq(virq_o[0]), .cpu_vector(vec_o[0]),
    .cpu_iako(iako_a[0]), .busy(busy_o[0]));

  virq_arbiter #(.N(N), .RR(1), .ACK_LEN(ACK_LEN), .DROP_TO(DROP_TO)) u_rr (
    .clk_sys(clk_sys), .bus_reset_n(bus_reset_n), .irq_en(irq_en_a[1]), .req(req_a[1]),
    .vec_in(vec_in), .ack(ack_o[1]), .cpu_virq(virq_o[1]), .cpu_vector(vec_o[1]),
    .cpu_iako(iako_a[1]), .busy(busy_o[1]));

  function automatic int pick(input logic [N-1:0] elig, input int last, input bit rr);
    for (int k = 0; k < int'(N); k++) begin
      int c;
      c = rr ? (last + 1 + k) % int'(N) : k;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] vec_of(input logic [N*9-1:0] v, input int i);
    logic [N*9-1:0] s;
    s = v >> (9 * i);
    return {7'd0, s[8:1], 1'b0};
  endfunction

  // Grant-level model: who owns the CPU line, what it is doing, what shows next edge.
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    int          owner, step, left, last_g, rel;
    logic        iako_prev;
    logic [15:0] lvec;
    logic        e_virq;
    logic [15:0] e_vec;
    logic [N-1:0] e_ack;
    logic        e_busy;

    always @(posedge clk_sys or negedge bus_reset_n) begin
      if (!bus_reset_n) begin
        rel <= 0; owner <= -1; step <= 0; left <= 0; last_g <= int'(N) - 1;
        iako_prev <= 1'b0; lvec <= '0;
        e_virq <= 1'b0; e_vec <= '0; e_ack <= '0; e_busy <= 1'b0;
      end else if (rel < 2) begin
        rel <= rel + 1;
      end else begin
        e_virq    <= (owner >= 0 && step == 0);
        e_vec     <= (owner >= 0 && step == 0) ? lvec : 16'd0;
        e_ack     <= (owner >= 0 && step == 1) ? (N'(1) << owner) : '0;
        e_busy    <= (owner >= 0);
        iako_prev <= iako_a[g];
        if (owner < 0) begin
          int w;
          w = pick(req_a[g] & {N{irq_en_a[g]}}, last_g, g == 1);
          if (w >= 0) begin
            owner <= w; step <= 0; lvec <= vec_of(vec_in, w);
          end
        end else if (step == 0) begin
          if (iako_a[g] && !iako_prev) begin
            step <= 1; left <= int'(ACK_LEN);
            if (g == 1) last_g <= owner;
          end else if (!req_a[g][owner] || !irq_en_a[g]) begin
            owner <= -1;
          end
        end else if (step == 1) begin
          if (left <= 1) begin step <= 2; left <= int'(DROP_TO); end
          else left <= left - 1;
        end else begin
          if (!req_a[g][owner] || left <= 1) begin owner <= -1; step <= 0; end
          else left <= left - 1;
        end
      end
    end
  end

  task automatic cmp(input int d, input logic ev, input logic [15:0] evec,
                     input logic [N-1:0] eack, input logic eb);
    n_vec++;
    if (virq_o[d] !== ev || vec_o[d] !== evec || ack_o[d] !== eack || busy_o[d] !== eb) begin
      n_bad++;
      $display("FAIL model[%0d] t=%0t virq/vec/ack/busy got %b/%o/%b/%b want %b/%o/%b/%b",
               d, $time, virq_o[d], vec_o[d], ack_o[d], busy_o[d], ev, evec, eack, eb);
    end
  endtask

  always @(negedge clk_sys) begin
    if (chk_on) begin
      cmp(0, g_mdl[0].e_virq, g_mdl[0].e_vec, g_mdl[0].e_ack, g_mdl[0].e_busy);
      cmp(1, g_mdl[1].e_virq, g_mdl[1].e_vec, g_mdl[1].e_ack, g_mdl[1].e_busy);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_virq(input int d, input int budget);
    int n;
    n = 0;
    while (virq_o[d] !== 1'b1 && n < budget) begin cyc(1); n++; end
    check($sformatf("virq_rise[%0d]", d), 32'(virq_o[d]), 32'd1);
  endtask

  task automatic pulse_iako(input int d);
    iako_a[d] = 1'b1;
    cyc(1);
    iako_a[d] = 1'b0;
  endtask

  task automatic wait_ack(input int d, output int idx);
    int n;
    n = 0;
    idx = -1;
    while (ack_o[d] === '0 && n < 20) begin cyc(1); n++; end
    for (int i = 0; i < int'(N); i++) if (ack_o[d][i] === 1'b1) idx = i;
    check($sformatf("ack_seen[%0d]", d), 32'(ack_o[d] !== '0), 32'd1);
  endtask

  task automatic wait_ack_low(input int d);
    int n;
    n = 0;
    while (ack_o[d] !== '0 && n < 20) begin cyc(1); n++; end
    check($sformatf("ack_low[%0d]", d), 32'(ack_o[d]), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t got running want finished", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int idx;
    int n;
    int grants [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    bus_reset_n = 1'b0;
    vec_in      = {9'o100, 9'o201, 9'o274, 9'o060};
    for (int d = 0; d < 2; d++) begin
      req_a[d] = '0; irq_en_a[d] = 1'b1; iako_a[d] = 1'b0;
    end
    cyc(2);
    chk_on = 1'b1;
    cyc(1);
    check("rst_virq", 32'(virq_o[0]), 32'd0);
    check("rst_ack", 32'(ack_o[0]), 32'd0);
    check("rst_vec", 32'(vec_o[0]), 32'd0);
    check("rst_busy", 32'(busy_o[0]), 32'd0);
    bus_reset_n = 1'b1;
    cyc(4);

    // Single keyboard request.
    req_a[0] = 4'b0001;
    cyc(1);
    check("kbd_virq_1edge", 32'(virq_o[0]), 32'd0);
    cyc(1);
    check("kbd_virq_2edge", 32'(virq_o[0]), 32'd1);
    check("kbd_vec", 32'(vec_o[0]), 32'o60);
    vec_in[8:0] = 9'o070;
    cyc(1);
    check("kbd_vec_held", 32'(vec_o[0]), 32'o60);
    vec_in[8:0] = 9'o060;
    pulse_iako(0);
    check("kbd_virq_pre_ack", 32'(virq_o[0]), 32'd1);
    cyc(1);
    check("kbd_ack_c1", 32'(ack_o[0]), 32'b0001);
    check("kbd_virq_in_ack", 32'(virq_o[0]), 32'd0);
    cyc(1);
    check("kbd_ack_c2", 32'(ack_o[0]), 32'b0001);
    cyc(1);
    check("kbd_ack_end", 32'(ack_o[0]), 32'd0);
    req_a[0] = '0;
    cyc(3);
    check("kbd_busy_idle", 32'(busy_o[0]), 32'd0);

    // Fixed-priority contention: 1 before 3.
    req_a[0] = 4'b1010;
    cyc(2);
    check("pri_vec1", 32'(vec_o[0]), 32'o274);
    pulse_iako(0);
    wait_ack(0, idx);
    check("pri_ack1", 32'(idx), 32'd1);
    wait_ack_low(0);
    req_a[0] = 4'b1000;
    wait_virq(0, 10);
    check("pri_vec3", 32'(vec_o[0]), 32'o100);
    pulse_iako(0);
    wait_ack(0, idx);
    check("pri_ack3", 32'(idx), 32'd3);
    wait_ack_low(0);
    req_a[0] = '0;
    cyc(3);

    // Enable gating, then withdraw without iako.
    irq_en_a[0] = 1'b0;
    req_a[0]    = 4'b0001;
    cyc(5);
    check("gate_virq", 32'(virq_o[0]), 32'd0);
    check("gate_busy", 32'(busy_o[0]), 32'd0);
    irq_en_a[0] = 1'b1;
    cyc(1);
    check("gate_virq_1edge", 32'(virq_o[0]), 32'd0);
    cyc(1);
    check("gate_virq_2edge", 32'(virq_o[0]), 32'd1);
    req_a[0] = '0;
    cyc(1);
    check("wd_virq_hold", 32'(virq_o[0]), 32'd1);
    cyc(1);
    check("wd_virq_fall", 32'(virq_o[0]), 32'd0);
    cyc(4);
    check("wd_no_ack", 32'(ack_o[0]), 32'd0);

    // iako edge and request drop in the same cycle: iako wins.
    req_a[0] = 4'b0001;
    wait_virq(0, 10);
    iako_a[0] = 1'b1;
    req_a[0]  = '0;
    cyc(1);
    iako_a[0] = 1'b0;
    wait_ack(0, idx);
    check("race_ack0", 32'(idx), 32'd0);
    wait_ack_low(0);
    cyc(3);

    // Stuck request: DROP times out after DROP_TO and index 2 is re-granted.
    req_a[0] = 4'b0100;
    wait_virq(0, 10);
    check("stuck_vec", 32'(vec_o[0]), 32'o200);
    pulse_iako(0);
    wait_ack(0, idx);
    check("stuck_ack2", 32'(idx), 32'd2);
    wait_ack_low(0);
    n = 0;
    while (virq_o[0] !== 1'b1 && n < 200) begin cyc(1); n++; end
    check("stuck_regrant_gap", 32'(n), 32'd65);
    check("stuck_regrant_vec", 32'(vec_o[0]), 32'o200);

    // Reset during ACK drops outputs immediately.
    pulse_iako(0);
    wait_ack(0, idx);
    #1 bus_reset_n = 1'b0;
    #1;
    check("rst_mid_ack", 32'(ack_o[0]), 32'd0);
    check("rst_mid_virq", 32'(virq_o[0]), 32'd0);
    check("rst_mid_busy", 32'(busy_o[0]), 32'd0);
    req_a[0] = '0;
    cyc(2);
    bus_reset_n = 1'b1;
    cyc(5);
    check("rst_after_busy", 32'(busy_o[0]), 32'd0);
    check("rst_after_virq", 32'(virq_o[0]), 32'd0);

    // Round-robin with all four requesting.
    req_a[1] = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_virq(1, 100);
      pulse_iako(1);
      wait_ack(1, idx);
      grants[k] = idx;
      wait_ack_low(1);
      if (idx >= 0) req_a[1][idx] = 1'b0;
      cyc(2);
      if (idx >= 0) req_a[1][idx] = 1'b1;
    end
    req_a[1] = '0;
    cyc(3);
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_grant%0d", k), 32'(grants[k]), 32'(exp_order[k]));

    // Withdraw keeps last: after granting 0, a withdrawn offer to 1 must not rotate.
    req_a[1] = 4'b0010;
    wait_virq(1, 10);
    check("rr_wd_vec", 32'(vec_o[1]), 32'o274);
    req_a[1] = '0;
    cyc(2);
    check("rr_wd_virq", 32'(virq_o[1]), 32'd0);
    cyc(2);
    req_a[1] = 4'b0011;
    cyc(2);
    check("rr_last_kept", 32'(vec_o[1]), 32'o274);
    req_a[1] = '0;
    cyc(5);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
